// File: rtl/noc_arbiter_rr.sv
// rtl/noc_arbiter_rr.sv - round-robin NoC output-port arbiter with RTS/DCTS handshake
// Packet locking holds the port until the tail flit moves; MAX_HOLD bounds a sticky owner.
module noc_arbiter_rr #(
    parameter int NUM_PORTS   = 5,
    parameter int LOCK_PACKET = 1,
    parameter int MAX_HOLD    = 0,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] tail,
    input  logic                 DCTS,
    output logic [NUM_PORTS-1:0] grant,
    output logic [NUM_PORTS-1:0] xbar_sel,
    output logic                 RTS,
    output logic                 busy
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0] owner;
    logic [NUM_PORTS-1:0] next_owner;
    logic [NUM_PORTS-1:0] cand;
    logic [IDX_W-1:0]     last;
    logic [IDX_W-1:0]     next_idx;
    logic [IDX_W-1:0]     scan_idx;
    logic [CNT_W-1:0]     hold_cnt;
    logic                 locked;
    logic                 xfer;
    logic                 owner_en;
    logic                 owner_change;
    logic                 expired;
    logic                 owner_req;
    logic                 other_req;
    logic                 owner_tail;
    logic                 found;

    assign busy       = |owner;
    assign xfer       = RTS & DCTS & busy;
    assign grant      = owner & {NUM_PORTS{xfer}};
    assign xbar_sel   = owner;
    assign owner_req  = |(req & owner);
    assign other_req  = |(req & ~owner);
    assign owner_tail = |(tail & owner);
    assign expired    = (MAX_HOLD != 0) && (hold_cnt >= CNT_W'(MAX_HOLD)) && other_req;

    // A raised RTS is a promise to the downstream router: no re-arbitration until it is honoured.
    assign owner_en     = !(RTS && !DCTS);
    assign owner_change = owner_en && (next_owner != owner);

    always_comb begin
        cand       = expired ? (req & ~owner) : req;
        next_owner = '0;
        next_idx   = '0;
        scan_idx   = '0;
        found      = 1'b0;
        if (busy && (locked || (owner_req && !expired))) begin
            next_owner = owner;
        end else begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                scan_idx = IDX_W'((int'(last) + 1 + k) % NUM_PORTS);
                if (!found && cand[scan_idx]) begin
                    next_owner[scan_idx] = 1'b1;
                    found                = 1'b1;
                end
            end
        end
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (next_owner[k]) begin
                next_idx = IDX_W'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner    <= '0;
            RTS      <= 1'b0;
            last     <= IDX_W'(NUM_PORTS - 1);
            hold_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            RTS <= busy && !xfer;
            if (owner_en) begin
                owner <= next_owner;
            end
            if (owner_change && (|next_owner)) begin
                last <= next_idx;
            end
            if (owner_change) begin
                hold_cnt <= '0;
            end else if (xfer && (hold_cnt != '1)) begin
                hold_cnt <= hold_cnt + CNT_W'(1);
            end
            if (LOCK_PACKET == 0) begin
                locked <= 1'b0;
            end else if (owner_en && (next_owner == '0)) begin
                locked <= 1'b0;
            end else if (xfer) begin
                locked <= !owner_tail;
            end
        end
    end

endmodule

// File: tb/tb_noc_arbiter_rr.sv
// tb/tb_noc_arbiter_rr.sv - self-checking bench for noc_arbiter_rr
// Two instances (packet-locking and fair non-locking) share stimulus; a flit-level model tracks both.
module tb_noc_arbiter_rr;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] tail;
    logic         dcts;
    logic [N-1:0] grant_a, xsel_a, grant_b, xsel_b;
    logic         rts_a, busy_a, rts_b, busy_b;

    always #5 clk = ~clk;

    noc_arbiter_rr #(.NUM_PORTS(N), .LOCK_PACKET(1), .MAX_HOLD(0), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .req(req), .tail(tail), .DCTS(dcts),
        .grant(grant_a), .xbar_sel(xsel_a), .RTS(rts_a), .busy(busy_a)
    );

    noc_arbiter_rr #(.NUM_PORTS(N), .LOCK_PACKET(0), .MAX_HOLD(2), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .req(req), .tail(tail), .DCTS(dcts),
        .grant(grant_b), .xbar_sel(xsel_b), .RTS(rts_b), .busy(busy_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model state: owner as a port number (-1 = idle), per instance.
    int m_owner[2];
    int m_last[2];
    int m_hold[2];
    bit m_locked[2];
    bit m_rts[2];
    int cfg_lock[2] = '{1, 0};
    int cfg_maxh[2] = '{0, 2};

    function automatic int onehot_idx(logic [N-1:0] v);
        int r = -1;
        for (int k = 0; k < N; k++) if (v[k]) r = k;
        return r;
    endfunction

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            m_owner[m] = -1; m_last[m] = N - 1; m_hold[m] = 0; m_locked[m] = 0; m_rts[m] = 0;
        end
    endfunction

    function automatic int model_next(int m);
        int  o     = m_owner[m];
        bit  bsy   = (o >= 0);
        bit  other = 0;
        bit  exp_f;
        int  i;
        for (int k = 0; k < N; k++) if (req[k] && k != o) other = 1;
        exp_f = (cfg_maxh[m] != 0) && (m_hold[m] >= cfg_maxh[m]) && other;
        if (bsy && m_locked[m]) return o;
        if (bsy && req[o] && !exp_f) return o;
        for (int k = 1; k <= N; k++) begin
            i = (m_last[m] + k) % N;
            if (!(exp_f && i == o) && req[i]) return i;
        end
        return -1;
    endfunction

    function automatic void model_update(int m);
        int o     = m_owner[m];
        bit bsy   = (o >= 0);
        bit xfer  = m_rts[m] && dcts && bsy;
        bit en    = !(m_rts[m] && !dcts);
        int nx    = model_next(m);
        int new_o = en ? nx : o;
        bit chg   = (new_o != o);
        m_rts[m] = bsy && !xfer;
        if (chg && new_o >= 0) m_last[m] = new_o;
        if (chg) m_hold[m] = 0;
        else if (xfer && m_hold[m] < 255) m_hold[m] = m_hold[m] + 1;
        if (cfg_lock[m] == 0) m_locked[m] = 0;
        else if (en && nx < 0) m_locked[m] = 0;
        else if (xfer) m_locked[m] = !tail[o];
        m_owner[m] = new_o;
    endfunction

    function automatic logic [2*N+1:0] model_outs(int m);
        logic [N-1:0] x;
        logic [N-1:0] g;
        bit           b;
        b = (m_owner[m] >= 0);
        x = b ? N'(1 << m_owner[m]) : '0;
        g = (m_rts[m] && dcts && b) ? x : '0;
        return {g, x, m_rts[m], b};
    endfunction

    task automatic advance();
        @(posedge clk);
        if (!rst) model_reset();
        else for (int m = 0; m < 2; m++) model_update(m);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; req = '0; tail = '0; dcts = 1'b0;
        model_reset();
        repeat (2) advance();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++;
        if ({grant_a, xsel_a, rts_a, busy_a} !== 12'b0) begin
            n_errors++; $display("FAIL reset_a: got %b want 0", {grant_a, xsel_a, rts_a, busy_a});
        end
        n_checks++;
        if ({grant_b, xsel_b, rts_b, busy_b} !== 12'b0) begin
            n_errors++; $display("FAIL reset_b: got %b want 0", {grant_b, xsel_b, rts_b, busy_b});
        end
        advance();
        @(negedge clk);
        n_checks++;
        if (busy_a !== 1'b0 || rts_a !== 1'b0) begin
            n_errors++; $display("FAIL idle_no_req: busy=%b rts=%b want 0 0", busy_a, rts_a);
        end
        advance();
    endtask

    task automatic test_single();
        logic [5:0]   eb = 6'b111110;
        logic [5:0]   er = 6'b010100;
        logic [N-1:0] eg;
        do_reset();
        req = 5'b00001; dcts = 1'b1; tail = 5'b11111;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            eg = er[c] ? 5'b00001 : 5'b00000;
            n_checks++;
            if ({busy_a, rts_a, grant_a} !== {eb[c], er[c], eg}) begin
                n_errors++;
                $display("FAIL single_a c%0d: busy/rts/grant %b %b %b want %b %b %b", c, busy_a, rts_a, grant_a, eb[c], er[c], eg);
            end
            n_checks++;
            if ({busy_b, rts_b, grant_b} !== {eb[c], er[c], eg}) begin
                n_errors++;
                $display("FAIL single_b c%0d: busy/rts/grant %b %b %b want %b %b %b", c, busy_b, rts_b, grant_b, eb[c], er[c], eg);
            end
            advance();
        end
    endtask

    task automatic test_stall();
        do_reset();
        req = 5'b00100; dcts = 1'b0; tail = 5'b11111;
        repeat (2) begin @(negedge clk); advance(); end
        req = 5'b00001;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (xsel_a !== 5'b00100 || grant_a !== 5'b0 || rts_a !== 1'b1) begin
                n_errors++; $display("FAIL stall_a c%0d: xsel=%b grant=%b rts=%b want 00100 00000 1", c, xsel_a, grant_a, rts_a);
            end
            n_checks++;
            if (xsel_b !== 5'b00100 || grant_b !== 5'b0) begin
                n_errors++; $display("FAIL stall_b c%0d: xsel=%b grant=%b want 00100 00000", c, xsel_b, grant_b);
            end
            advance();
        end
        dcts = 1'b1;
        @(negedge clk);
        n_checks++;
        if (grant_a !== 5'b00100 || grant_b !== 5'b00100) begin
            n_errors++; $display("FAIL stall_release: grant_a=%b grant_b=%b want 00100", grant_a, grant_b);
        end
        advance();
        @(negedge clk);
        n_checks++;
        if (xsel_a !== 5'b00001 || rts_a !== 1'b0) begin
            n_errors++; $display("FAIL stall_handover: xsel=%b rts=%b want 00001 0", xsel_a, rts_a);
        end
        advance();
    endtask

    task automatic test_round_robin();
        int           got[$];
        int           want[6] = '{0, 1, 2, 3, 4, 0};
        logic [N-1:0] g;
        do_reset();
        req = 5'b11111; tail = 5'b11111; dcts = 1'b1;
        for (int c = 0; c < 60 && got.size() < 6; c++) begin
            @(negedge clk);
            g = grant_b;
            advance();
            if (g != '0) begin
                got.push_back(onehot_idx(g));
                req = 5'b11111 & ~g;
            end
        end
        n_checks++;
        if (got.size() != 6) begin
            n_errors++; $display("FAIL rr_timeout: got %0d grants want 6", got.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                n_checks++;
                if (got[k] != want[k]) begin
                    n_errors++; $display("FAIL rr_order[%0d]: got port %0d want %0d", k, got[k], want[k]);
                end
            end
        end
    endtask

    task automatic test_packet_lock();
        int           got[$];
        int           want[4] = '{1, 1, 1, 2};
        int           cnt1 = 0;
        logic [N-1:0] g;
        do_reset();
        req = 5'b11110; tail = 5'b11101; dcts = 1'b1;
        for (int c = 0; c < 60 && got.size() < 4; c++) begin
            @(negedge clk);
            g = grant_a;
            advance();
            if (g != '0) got.push_back(onehot_idx(g));
            if (g == 5'b00010) cnt1++;
            req  = (cnt1 >= 3) ? 5'b11101 : 5'b11111;
            tail = (cnt1 == 2) ? 5'b11111 : 5'b11101;
        end
        n_checks++;
        if (got.size() != 4) begin
            n_errors++; $display("FAIL lock_timeout: got %0d grants want 4", got.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (got[k] != want[k]) begin
                    n_errors++; $display("FAIL lock_order[%0d]: got port %0d want %0d", k, got[k], want[k]);
                end
            end
        end
    endtask

    task automatic test_fairness();
        int got_a[$];
        int got_b[$];
        int want_b[4] = '{0, 0, 3, 3};
        do_reset();
        req = 5'b01001; tail = 5'b11111; dcts = 1'b1;
        for (int c = 0; c < 40 && (got_a.size() < 4 || got_b.size() < 4); c++) begin
            @(negedge clk);
            if (grant_a != '0) got_a.push_back(onehot_idx(grant_a));
            if (grant_b != '0) got_b.push_back(onehot_idx(grant_b));
            advance();
        end
        n_checks++;
        if (got_a.size() < 4 || got_b.size() < 4) begin
            n_errors++; $display("FAIL fair_timeout: grants a=%0d b=%0d want 4 each", got_a.size(), got_b.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (got_b[k] != want_b[k]) begin
                    n_errors++; $display("FAIL fair_b[%0d]: got port %0d want %0d", k, got_b[k], want_b[k]);
                end
                n_checks++;
                if (got_a[k] != 0) begin
                    n_errors++; $display("FAIL unlimited_a[%0d]: got port %0d want 0", k, got_a[k]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 5'b00001; tail = 5'b00000; dcts = 1'b1;
        repeat (4) begin @(negedge clk); advance(); end
        @(negedge clk);
        n_checks++;
        if (rts_a !== 1'b1 || busy_a !== 1'b1) begin
            n_errors++; $display("FAIL pre_reset: rts=%b busy=%b want 1 1", rts_a, busy_a);
        end
        #2 rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({grant_a, xsel_a, rts_a, busy_a} !== 12'b0) begin
            n_errors++; $display("FAIL async_reset_a: got %b want 0", {grant_a, xsel_a, rts_a, busy_a});
        end
        n_checks++;
        if ({grant_b, xsel_b, rts_b, busy_b} !== 12'b0) begin
            n_errors++; $display("FAIL async_reset_b: got %b want 0", {grant_b, xsel_b, rts_b, busy_b});
        end
        advance();
        rst = 1'b1; req = 5'b10001;
        @(negedge clk);
        advance();
        @(negedge clk);
        n_checks++;
        if (xsel_a !== 5'b00001 || xsel_b !== 5'b00001) begin
            n_errors++; $display("FAIL post_reset_scan: xsel_a=%b xsel_b=%b want 00001", xsel_a, xsel_b);
        end
        advance();
    endtask

    task automatic test_random();
        logic [2*N+1:0] ea, eb;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            req  = N'($urandom);
            tail = N'($urandom);
            dcts = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b0;
                model_reset();
            end else begin
                rst = 1'b1;
            end
            @(negedge clk);
            ea = model_outs(0);
            eb = model_outs(1);
            n_checks++;
            if ({grant_a, xsel_a, rts_a, busy_a} !== ea) begin
                n_errors++; $display("FAIL rand_a c%0d: grant/xsel/rts/busy %b want %b", c, {grant_a, xsel_a, rts_a, busy_a}, ea);
            end
            n_checks++;
            if ({grant_b, xsel_b, rts_b, busy_b} !== eb) begin
                n_errors++; $display("FAIL rand_b c%0d: grant/xsel/rts/busy %b want %b", c, {grant_b, xsel_b, rts_b, busy_b}, eb);
            end
            n_checks++;
            if ($countones(xsel_a) > 1 || $countones(xsel_b) > 1) begin
                n_errors++; $display("FAIL rand_onehot c%0d: xsel_a=%b xsel_b=%b want at most one bit", c, xsel_a, xsel_b);
            end
            advance();
        end
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; req = '0; tail = '0; dcts = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_stall();
        test_round_robin();
        test_packet_lock();
        test_fairness();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
